// File: rtl/fb_pkg.sv
// Shared framebuffer definitions. The scanout engine and the framebuffer
// arbiter both use this package.
//   - issue_state_e : what the arbiter put into the RAM last cycle
//   - fb_tag_t      : per-issue response tag {vid, cpu, oor}
//   - FB_BITS_PER_PIXEL / FB_DEPTH : default pixel width and pixel count
package fb_pkg;
  localparam int FB_BITS_PER_PIXEL = 3;
  localparam int FB_DEPTH          = 640 * 480;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VID    = 2'd1,
    S_CPU_RD = 2'd2,
    S_CPU_WR = 2'd3
  } issue_state_e;

  // vid/cpu: which port receives the read response; oor: force data to 0.
  typedef struct packed {
    logic vid;
    logic cpu;
    logic oor;
  } fb_tag_t;
endpackage

// File: rtl/fb_arb_resp_pipe.sv
// Response side of the framebuffer arbiter. The tag for an issue arrives
// at T+1, when the RAM address is being presented. It is registered once
// more, so that it lines up with i_Ram_Rdata at T+2. The tag then steers
// the RAM data to the video or CPU port, or forces it to 0 when the
// address was out of range.
// Ports:
//   i_Clock, i_Reset_N     clock, async active-low reset
//   i_Tag                  tag of the access the RAM is serving (T+1)
//   i_Ram_Rdata            RAM read data (T+2)
//   o_Vid_Rvalid/o_Vid_Rdata, o_Cpu_Rvalid/o_Cpu_Rdata  responses
module fb_arb_resp_pipe
  import fb_pkg::*;
#(
  parameter int BITS_PER_PIXEL = FB_BITS_PER_PIXEL
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  fb_tag_t                   i_Tag,
  input  logic [BITS_PER_PIXEL-1:0] i_Ram_Rdata,
  output logic                      o_Vid_Rvalid,
  output logic [BITS_PER_PIXEL-1:0] o_Vid_Rdata,
  output logic                      o_Cpu_Rvalid,
  output logic [BITS_PER_PIXEL-1:0] o_Cpu_Rdata
);
  fb_tag_t                   tag_q;
  logic [BITS_PER_PIXEL-1:0] rdata;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) tag_q <= '0;
    else            tag_q <= i_Tag;
  end

  // The RAM was not accessed for an out-of-range issue. Whatever it
  // returns belongs to a stale address, so it is discarded.
  assign rdata        = tag_q.oor ? '0 : i_Ram_Rdata;
  assign o_Vid_Rvalid = tag_q.vid;
  assign o_Cpu_Rvalid = tag_q.cpu;
  assign o_Vid_Rdata  = tag_q.vid ? rdata : '0;
  assign o_Cpu_Rdata  = tag_q.cpu ? rdata : '0;
endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter. Video reads have absolute priority and take
// exactly 2 cycles. CPU reads and writes use the idle cycles through a
// valid/ready handshake. The RAM address, write enable and write data are
// registered (T+1). Read data comes back at T+2 and is steered to the
// requester.
// An address at or above FRAMEBUFFER_DEPTH never reaches the RAM: a read
// returns 0, and a write is dropped.
// Optional: define FB_ARB_PERF_EN to add o_Perf_Cpu_Xfers and
// o_Perf_Cpu_Stalls. Both are wrapping 32-bit counters.
// Ports:
//   i_Clock, i_Reset_N                     clock, async active-low reset
//   i_Vid_Req/i_Vid_Addr                   video read request
//   o_Vid_Rvalid/o_Vid_Rdata               video response
//   i_Cpu_Valid/o_Cpu_Ready/i_Cpu_We/i_Cpu_Addr/i_Cpu_Wdata  CPU request
//   o_Cpu_Rvalid/o_Cpu_Rdata               CPU read response
//   o_Cpu_Starved                          sticky starvation flag
//   o_Ram_Addr/o_Ram_We/o_Ram_Wdata/i_Ram_Rdata  RAM port
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int BITS_PER_PIXEL    = FB_BITS_PER_PIXEL,
  parameter int FRAMEBUFFER_DEPTH = FB_DEPTH,
  parameter int ADDR_WIDTH        = 32,
  parameter int CPU_MAX_WAIT      = 16
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic                      i_Vid_Req,
  input  logic [ADDR_WIDTH-1:0]     i_Vid_Addr,
  output logic [BITS_PER_PIXEL-1:0] o_Vid_Rdata,
  output logic                      o_Vid_Rvalid,
  input  logic                      i_Cpu_Valid,
  output logic                      o_Cpu_Ready,
  input  logic                      i_Cpu_We,
  input  logic [ADDR_WIDTH-1:0]     i_Cpu_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Cpu_Wdata,
  output logic [BITS_PER_PIXEL-1:0] o_Cpu_Rdata,
  output logic                      o_Cpu_Rvalid,
  output logic                      o_Cpu_Starved,
  output logic [ADDR_WIDTH-1:0]     o_Ram_Addr,
  output logic                      o_Ram_We,
  output logic [BITS_PER_PIXEL-1:0] o_Ram_Wdata,
  input  logic [BITS_PER_PIXEL-1:0] i_Ram_Rdata
`ifdef FB_ARB_PERF_EN
  ,
  output logic [31:0]               o_Perf_Cpu_Xfers,
  output logic [31:0]               o_Perf_Cpu_Stalls
`endif
);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(FRAMEBUFFER_DEPTH);
  localparam int                    CW    = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CW-1:0]         MAX_W = CW'(CPU_MAX_WAIT);

  issue_state_e              state_q, state_d;
  logic                      oor_q, oor_d;
  logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
  logic                      ram_we_q, ram_we_d;
  logic [BITS_PER_PIXEL-1:0] ram_wdata_q, ram_wdata_d;
  logic [CW-1:0]             wait_q, wait_d;
  logic                      starved_q, starved_d;
  logic                      vid_oor, cpu_oor, stall;
  fb_tag_t                   tag_s1;

  // Ready is held low while reset is asserted, so that no transfer can
  // complete during reset.
  assign o_Cpu_Ready = i_Reset_N & i_Cpu_Valid & ~i_Vid_Req;
  assign stall       = i_Cpu_Valid & ~o_Cpu_Ready;
  assign vid_oor     = (i_Vid_Addr >= DEPTH);
  assign cpu_oor     = (i_Cpu_Addr >= DEPTH);

  // Issue decision. The RAM address and write data hold their values
  // unless an in-range access is issued, so out-of-range traffic leaves
  // the RAM port untouched.
  always_comb begin
    state_d     = S_IDLE;
    oor_d       = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (i_Vid_Req) begin
      state_d = S_VID;
      oor_d   = vid_oor;
      if (!vid_oor) ram_addr_d = i_Vid_Addr;
    end else if (o_Cpu_Ready) begin
      state_d = i_Cpu_We ? S_CPU_WR : S_CPU_RD;
      oor_d   = cpu_oor;
      if (!cpu_oor) begin
        ram_addr_d = i_Cpu_Addr;
        ram_we_d   = i_Cpu_We;
        if (i_Cpu_We) ram_wdata_d = i_Cpu_Wdata;
      end
    end
  end

  // Consecutive-stall counter. It saturates at CPU_MAX_WAIT, and the
  // starvation flag latches on the cycle the counter gets there.
  always_comb begin
    wait_d = '0;
    if (stall) wait_d = (wait_q == MAX_W) ? wait_q : wait_q + 1'b1;
    starved_d = starved_q | (wait_d == MAX_W);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q     <= S_IDLE;
      oor_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wait_q      <= '0;
      starved_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      oor_q       <= oor_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wait_q      <= wait_d;
      starved_q   <= starved_d;
    end
  end

  // The issue state acts as the first tag stage. Writes never produce a
  // response.
  assign tag_s1.vid = (state_q == S_VID);
  assign tag_s1.cpu = (state_q == S_CPU_RD);
  assign tag_s1.oor = oor_q;

  fb_arb_resp_pipe #(.BITS_PER_PIXEL(BITS_PER_PIXEL)) u_resp (
    .i_Clock      (i_Clock),
    .i_Reset_N    (i_Reset_N),
    .i_Tag        (tag_s1),
    .i_Ram_Rdata  (i_Ram_Rdata),
    .o_Vid_Rvalid (o_Vid_Rvalid),
    .o_Vid_Rdata  (o_Vid_Rdata),
    .o_Cpu_Rvalid (o_Cpu_Rvalid),
    .o_Cpu_Rdata  (o_Cpu_Rdata)
  );

  assign o_Ram_Addr    = ram_addr_q;
  assign o_Ram_We      = ram_we_q;
  assign o_Ram_Wdata   = ram_wdata_q;
  assign o_Cpu_Starved = starved_q;

`ifdef FB_ARB_PERF_EN
  logic [31:0] perf_xfers_q, perf_stalls_q;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      perf_xfers_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (o_Cpu_Ready) perf_xfers_q  <= perf_xfers_q + 32'd1;
      if (stall)       perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign o_Perf_Cpu_Xfers  = perf_xfers_q;
  assign o_Perf_Cpu_Stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;
  localparam logic [31:0] DEPTH = 32'd307200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_req = 1'b0, cpu_valid = 1'b0, cpu_we = 1'b0;
  logic [31:0] vid_addr = '0, cpu_addr = '0;
  logic [2:0]  cpu_wdata = '0;
  logic [2:0]  vid_rdata, cpu_rdata, ram_wdata, ram_rdata;
  logic        vid_rvalid, cpu_ready, cpu_rvalid, starved, ram_we;
  logic [31:0] ram_addr;
`ifdef FB_ARB_PERF_EN
  logic [31:0] perf_xfers, perf_stalls;
`endif

  int checks = 0;
  int failures = 0;

  // RAM contents and reference contents, both sparse. An address never
  // written holds init_val(addr), so for example init_val(5) = 3'b101.
  logic [2:0] ram_mem [logic [31:0]];
  logic [2:0] shadow  [logic [31:0]];

  typedef struct {int due; bit vid; logic [2:0] d;} rsp_t;
  rsp_t rq[$];

  always #5 clk = ~clk;

  fb_arbiter dut (
    .i_Clock(clk), .i_Reset_N(rst_n),
    .i_Vid_Req(vid_req), .i_Vid_Addr(vid_addr),
    .o_Vid_Rdata(vid_rdata), .o_Vid_Rvalid(vid_rvalid),
    .i_Cpu_Valid(cpu_valid), .o_Cpu_Ready(cpu_ready), .i_Cpu_We(cpu_we),
    .i_Cpu_Addr(cpu_addr), .i_Cpu_Wdata(cpu_wdata),
    .o_Cpu_Rdata(cpu_rdata), .o_Cpu_Rvalid(cpu_rvalid),
    .o_Cpu_Starved(starved),
    .o_Ram_Addr(ram_addr), .o_Ram_We(ram_we), .o_Ram_Wdata(ram_wdata),
    .i_Ram_Rdata(ram_rdata)
`ifdef FB_ARB_PERF_EN
    , .o_Perf_Cpu_Xfers(perf_xfers), .o_Perf_Cpu_Stalls(perf_stalls)
`endif
  );

  function automatic logic [2:0] init_val(input logic [31:0] a);
    return a[2:0] ^ a[5:3];
  endfunction

  function automatic logic [2:0] mem_val(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // Single-port RAM with a registered 1-cycle read.
  always @(posedge clk) begin
    logic [2:0] rd;
    rd = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_val(ram_addr);
    if (ram_we) ram_mem[ram_addr] = ram_wdata;
    ram_rdata <= rd;
  end

  function automatic logic [31:0] pick_addr();
    logic [31:0] b [4];
    b[0] = 32'd307199; b[1] = 32'd307200; b[2] = 32'd400000; b[3] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 9) == 0) return b[$urandom_range(0, 3)];
    return 32'($urandom_range(0, 31));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; vid_req = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b want 0", cpu_ready);
    end
    checks++;
    if ({ram_addr, ram_we, ram_wdata} !== 36'd0) begin
      failures++; $display("FAIL reset_ram: got addr=%0h we=%b wd=%0h want 0", ram_addr, ram_we, ram_wdata);
    end
    checks++;
    if ({vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata, starved} !== 9'd0) begin
      failures++; $display("FAIL reset_resp: got vv=%b cv=%b vd=%0h cd=%0h st=%b want 0",
                           vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata, starved);
    end
    cpu_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_video();
    vid_req = 1'b1; vid_addr = 32'd5;
    @(posedge clk); #1;
    vid_req = 1'b0;
    checks++;
    if (ram_addr !== 32'd5 || ram_we !== 1'b0) begin
      failures++; $display("FAIL vid_ram_addr: got addr=%0d we=%b want 5/0", ram_addr, ram_we);
    end
    @(posedge clk); #1;
    checks++;
    if (vid_rvalid !== 1'b1 || vid_rdata !== 3'b101 || cpu_rvalid !== 1'b0) begin
      failures++; $display("FAIL vid_resp: got vv=%b vd=%b cv=%b want 1/101/0", vid_rvalid, vid_rdata, cpu_rvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (vid_rvalid !== 1'b0 || vid_rdata !== 3'b000) begin
      failures++; $display("FAIL vid_resp_end: got vv=%b vd=%b want 0/0", vid_rvalid, vid_rdata);
    end
  endtask

  task automatic test_cpu_wr_rd();
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd100; cpu_wdata = 3'b011;
    #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      failures++; $display("FAIL wr_ready: got %b want 1", cpu_ready);
    end
    @(posedge clk); #1;
    shadow[32'd100] = 3'b011;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 32'd100 || ram_wdata !== 3'b011) begin
      failures++; $display("FAIL wr_ram: got we=%b addr=%0d wd=%b want 1/100/011", ram_we, ram_addr, ram_wdata);
    end
    cpu_we = 1'b0;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 32'd100) begin
      failures++; $display("FAIL wr_one_cycle: got we=%b addr=%0d want 0/100", ram_we, ram_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 3'b011 || vid_rvalid !== 1'b0) begin
      failures++; $display("FAIL rd_after_wr: got cv=%b cd=%b vv=%b want 1/011/0", cpu_rvalid, cpu_rdata, vid_rvalid);
    end
  endtask

  task automatic test_collision();
    vid_req = 1'b1; vid_addr = 32'd7; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd8;
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++; $display("FAIL coll_ready_low: got %b want 0", cpu_ready);
    end
    @(posedge clk); #1;
    vid_req = 1'b0; #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      failures++; $display("FAIL coll_ready_retry: got %b want 1", cpu_ready);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    checks++;
    if (vid_rvalid !== 1'b1 || vid_rdata !== mem_val(32'd7) || cpu_rvalid !== 1'b0) begin
      failures++; $display("FAIL coll_vid: got vv=%b vd=%b cv=%b want 1/%b/0", vid_rvalid, vid_rdata, cpu_rvalid, mem_val(32'd7));
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== mem_val(32'd8) || vid_rvalid !== 1'b0) begin
      failures++; $display("FAIL coll_cpu: got cv=%b cd=%b vv=%b want 1/%b/0", cpu_rvalid, cpu_rdata, vid_rvalid, mem_val(32'd8));
    end
  endtask

  task automatic test_oor();
    vid_req = 1'b1; vid_addr = 32'd5;
    @(posedge clk); #1;
    vid_addr = 32'd307200;
    @(posedge clk); #1;
    vid_req = 1'b0;
    checks++;
    if (ram_addr !== 32'd5 || ram_we !== 1'b0) begin
      failures++; $display("FAIL oor_no_access: got addr=%0d we=%b want 5/0", ram_addr, ram_we);
    end
    @(posedge clk); #1;
    checks++;
    if (vid_rvalid !== 1'b1 || vid_rdata !== 3'b000) begin
      failures++; $display("FAIL oor_vid_zero: got vv=%b vd=%b (ram=%b) want 1/000", vid_rvalid, vid_rdata, ram_rdata);
    end
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd400000; cpu_wdata = 3'b110;
    #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      failures++; $display("FAIL oor_wr_ready: got %b want 1", cpu_ready);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_we = 1'b0;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 32'd5) begin
      failures++; $display("FAIL oor_wr_dropped: got we=%b addr=%0d want 0/5", ram_we, ram_addr);
    end
  endtask

  task automatic test_random(input int n);
    int t;
    bit hold, exp_we, exp_acc, drain, in_rng, ev, ecv;
    logic [31:0] exp_addr;
    logic [2:0]  exp_wd, evd, ecd;
    t = 0; hold = 1'b0; exp_addr = '0; exp_wd = '0;
    vid_req = 1'b0; cpu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rq.delete();
    for (int k = 0; k < n; k++) begin
      drain = (k >= n - 3);
      vid_req  = drain ? 1'b0 : ($urandom_range(0, 99) < 40);
      vid_addr = pick_addr();
      if (!hold) begin
        cpu_valid = drain ? 1'b0 : ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = pick_addr();
        cpu_wdata = 3'($urandom_range(0, 7));
      end
      #1;
      checks++;
      if (cpu_ready !== (cpu_valid & ~vid_req)) begin
        failures++; $display("FAIL rnd_ready@%0d: got %b want %b", t, cpu_ready, cpu_valid & ~vid_req);
      end
      exp_we = 1'b0; exp_acc = 1'b0;
      if (vid_req) begin
        in_rng = (vid_addr < DEPTH);
        if (in_rng) begin exp_acc = 1'b1; exp_addr = vid_addr; end
        rq.push_back('{t + 2, 1'b1, in_rng ? mem_val(vid_addr) : 3'b000});
      end else if (cpu_valid) begin
        in_rng = (cpu_addr < DEPTH);
        if (cpu_we) begin
          if (in_rng) begin
            exp_acc = 1'b1; exp_we = 1'b1; exp_addr = cpu_addr; exp_wd = cpu_wdata;
            shadow[cpu_addr] = cpu_wdata;
          end
        end else begin
          if (in_rng) begin exp_acc = 1'b1; exp_addr = cpu_addr; end
          rq.push_back('{t + 2, 1'b0, in_rng ? mem_val(cpu_addr) : 3'b000});
        end
      end
      hold = cpu_valid & vid_req;
      @(posedge clk); #1;
      t++;
      checks++;
      if (ram_we !== exp_we || (exp_acc && ram_addr !== exp_addr) || (exp_we && ram_wdata !== exp_wd)) begin
        failures++; $display("FAIL rnd_ram@%0d: got we=%b addr=%0h wd=%b want we=%b addr=%0h wd=%b",
                             t, ram_we, ram_addr, ram_wdata, exp_we, exp_addr, exp_wd);
      end
      ev = 1'b0; ecv = 1'b0; evd = '0; ecd = '0;
      if (rq.size() > 0 && rq[0].due == t) begin
        if (rq[0].vid) begin ev = 1'b1; evd = rq[0].d; end
        else begin ecv = 1'b1; ecd = rq[0].d; end
        void'(rq.pop_front());
      end
      checks++;
      if (vid_rvalid !== ev || vid_rdata !== evd || cpu_rvalid !== ecv || cpu_rdata !== ecd) begin
        failures++; $display("FAIL rnd_resp@%0d: got vv=%b vd=%b cv=%b cd=%b want %b/%b/%b/%b",
                             t, vid_rvalid, vid_rdata, cpu_rvalid, cpu_rdata, ev, evd, ecv, ecd);
      end
    end
    cpu_valid = 1'b0; vid_req = 1'b0;
  endtask

  task automatic test_starve();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3; vid_req = 1'b1; vid_addr = 32'd4;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (starved !== (k >= 16)) begin
        failures++; $display("FAIL starve_after_%0d: got %b want %b", k, starved, (k >= 16));
      end
    end
    vid_req = 1'b0;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (starved !== 1'b1) begin
      failures++; $display("FAIL starve_sticky: got %b want 1", starved);
    end
  endtask

  task automatic test_reset_midflight();
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++;
    if ({cpu_ready, ram_addr, ram_we, ram_wdata, vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata, starved} !== 46'd0) begin
      failures++; $display("FAIL midrst_outputs: got rdy=%b addr=%0h we=%b wd=%b vv=%b cv=%b vd=%b cd=%b st=%b want 0",
                           cpu_ready, ram_addr, ram_we, ram_wdata, vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata, starved);
    end
    @(posedge clk); @(posedge clk); #1;
    cpu_valid = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (vid_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
        failures++; $display("FAIL midrst_no_rvalid_%0d: got vv=%b cv=%b want 0/0", k, vid_rvalid, cpu_rvalid);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_video();
    test_cpu_wr_rd();
    test_collision();
    test_oor();
    test_random(400);
    test_starve();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
